// File: rtl/lvt_multiport_ram.sv
// Two-write / two-read RAM built from simple-dual-port banks, one bank per write port
// replicated per read port, with a live-value table choosing which bank holds the newest word.
module lvt_multiport_ram #(
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 2 ** ADDR_WIDTH,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  wren1,
  input  logic [ADDR_WIDTH-1:0] wraddr1,
  input  logic [DATA_WIDTH-1:0] wrdata1,
  input  logic                  wren2,
  input  logic [ADDR_WIDTH-1:0] wraddr2,
  input  logic [DATA_WIDTH-1:0] wrdata2,
  input  logic                  rden1,
  input  logic [ADDR_WIDTH-1:0] rdaddr1,
  output logic [DATA_WIDTH-1:0] rddata1,
  input  logic                  rden2,
  input  logic [ADDR_WIDTH-1:0] rdaddr2,
  output logic [DATA_WIDTH-1:0] rddata2
);

  logic [DATA_WIDTH-1:0] bank1Rep1_q [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] bank1Rep2_q [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] bank2Rep1_q [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] bank2Rep2_q [RAM_DEPTH];
  logic [RAM_DEPTH-1:0]  lvt_q;
  logic [DATA_WIDTH-1:0] rdData1_q, rdData1_d;
  logic [DATA_WIDTH-1:0] rdData2_q, rdData2_d;

  // Banks carry no reset so they map onto block RAM; reset only blocks writes.
  always_ff @(posedge aclk) begin
    if (!areset && wren1) begin
      bank1Rep1_q[wraddr1] <= wrdata1;
      bank1Rep2_q[wraddr1] <= wrdata1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!areset && wren2) begin
      bank2Rep1_q[wraddr2] <= wrdata2;
      bank2Rep2_q[wraddr2] <= wrdata2;
    end
  end

  // Port 2 is assigned last so it wins a same-address collision.
  always_ff @(posedge aclk) begin
    if (areset) begin
      lvt_q <= '0;
    end else begin
      if (wren1) lvt_q[wraddr1] <= 1'b0;
      if (wren2) lvt_q[wraddr2] <= 1'b1;
    end
  end

  always_comb begin
    rdData1_d = rdData1_q;
    if (areset) begin
      rdData1_d = '0;
    end else if (rden1) begin
      rdData1_d = lvt_q[rdaddr1] ? bank2Rep1_q[rdaddr1] : bank1Rep1_q[rdaddr1];
    end
  end

  always_comb begin
    rdData2_d = rdData2_q;
    if (areset) begin
      rdData2_d = '0;
    end else if (rden2) begin
      rdData2_d = lvt_q[rdaddr2] ? bank2Rep2_q[rdaddr2] : bank1Rep2_q[rdaddr2];
    end
  end

  always_ff @(posedge aclk) begin
    rdData1_q <= rdData1_d;
    rdData2_q <= rdData2_d;
  end

  assign rddata1 = rdData1_q;
  assign rddata2 = rdData2_q;

endmodule

// File: tb/tb_lvt_multiport_ram.sv
// Directed plus short random bench for lvt_multiport_ram; expectations come from a
// reference memory that remembers the last writer of each address.
module tb_lvt_multiport_ram;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          aclk = 1'b0;
  logic          areset;
  logic          wren1, wren2, rden1, rden2;
  logic [AW-1:0] wraddr1, wraddr2, rdaddr1, rdaddr2;
  logic [DW-1:0] wrdata1, wrdata2;
  logic [DW-1:0] rddata1, rddata2;

  typedef struct {
    string         tag;
    bit            port;
    logic [DW-1:0] expVal;
  } exp_t;

  exp_t          scoreboard[$];
  logic [DW-1:0] refMem[int];
  int            refWriter[int];
  logic [DW-1:0] lastRd1, lastRd2;
  bit            known1, known2;
  int            checks = 0;
  int            errors = 0;

  lvt_multiport_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .aclk(aclk), .areset(areset),
    .wren1(wren1), .wraddr1(wraddr1), .wrdata1(wrdata1),
    .wren2(wren2), .wraddr2(wraddr2), .wrdata2(wrdata2),
    .rden1(rden1), .rdaddr1(rdaddr1), .rddata1(rddata1),
    .rden2(rden2), .rdaddr2(rdaddr2), .rddata2(rddata2)
  );

  always #5 aclk = ~aclk;

  // Pops every expectation queued for this edge and compares it with the live output.
  task automatic checkOutput();
    exp_t e;
    logic [DW-1:0] obs;
    while (scoreboard.size() > 0) begin
      e = scoreboard.pop_front();
      obs = e.port ? rddata2 : rddata1;
      checks++;
      assert (obs === e.expVal) else begin
        errors++;
        $error("FAIL %s port%0d observed %h expected %h", e.tag, e.port + 1, obs, e.expVal);
      end
    end
  endtask

  // Drives one cycle, derives the expected read data from the model as it stood
  // before this edge's writes, then updates the model and checks after the edge.
  task automatic applyStimulus(input string tag, input bit rst,
                               input bit w1, input int a1, input logic [DW-1:0] d1,
                               input bit w2, input int a2, input logic [DW-1:0] d2,
                               input bit r1, input int ra1,
                               input bit r2, input int ra2);
    exp_t e;
    areset = rst;
    wren1 = w1; wraddr1 = AW'(a1); wrdata1 = d1;
    wren2 = w2; wraddr2 = AW'(a2); wrdata2 = d2;
    rden1 = r1; rdaddr1 = AW'(ra1);
    rden2 = r2; rdaddr2 = AW'(ra2);
    if (rst) begin
      lastRd1 = '0; lastRd2 = '0; known1 = 1; known2 = 1;
      foreach (refWriter[k]) if (refWriter[k] == 2) refMem.delete(k);
      refWriter.delete();
      foreach (refMem[k]) refWriter[k] = 1;
    end else begin
      if (r1) begin
        known1 = refMem.exists(ra1);
        lastRd1 = known1 ? refMem[ra1] : 'x;
      end
      if (r2) begin
        known2 = refMem.exists(ra2);
        lastRd2 = known2 ? refMem[ra2] : 'x;
      end
      if (w1) begin refMem[a1] = d1; refWriter[a1] = 1; end
      if (w2) begin refMem[a2] = d2; refWriter[a2] = 2; end
    end
    if (known1) begin e.tag = tag; e.port = 0; e.expVal = lastRd1; scoreboard.push_back(e); end
    if (known2) begin e.tag = tag; e.port = 1; e.expVal = lastRd2; scoreboard.push_back(e); end
    @(posedge aclk);
    #1;
    checkOutput();
  endtask

  initial begin
    known1 = 0; known2 = 0;
    areset = 1'b0;
    wren1 = 0; wren2 = 0; rden1 = 0; rden2 = 0;
    wraddr1 = '0; wraddr2 = '0; rdaddr1 = '0; rdaddr2 = '0;
    wrdata1 = '0; wrdata2 = '0;
    @(posedge aclk);
    #1;

    applyStimulus("reset",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("wr10",        0, 1, 'h10, 32'hAAAA0001, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("rd10",        0, 0, 0, 0, 0, 0, 0, 1, 'h10, 1, 'h10);
    applyStimulus("idle_hold",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("wr05_06",     0, 1, 'h05, 32'h11111111, 1, 'h06, 32'h22222222, 0, 0, 0, 0);
    applyStimulus("rd05_06",     0, 0, 0, 0, 0, 0, 0, 1, 'h05, 1, 'h06);
    applyStimulus("collide20",   0, 1, 'h20, 32'h1, 1, 'h20, 32'h2, 0, 0, 0, 0);
    applyStimulus("rd20",        0, 0, 0, 0, 0, 0, 0, 1, 'h20, 1, 'h20);
    applyStimulus("wr30_p2",     0, 0, 0, 0, 1, 'h30, 32'hB, 0, 0, 0, 0);
    applyStimulus("wr30_p1",     0, 1, 'h30, 32'hC, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("rd30",        0, 0, 0, 0, 0, 0, 0, 1, 'h30, 1, 'h30);
    applyStimulus("wr40",        0, 1, 'h40, 32'h5, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("rdw40_old",   0, 0, 0, 0, 1, 'h40, 32'h6, 1, 'h40, 0, 0);
    applyStimulus("rd40_new",    0, 0, 0, 0, 0, 0, 0, 1, 'h40, 1, 'h40);
    applyStimulus("wr41",        0, 1, 'h41, 32'h7, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("rd41",        0, 0, 0, 0, 0, 0, 0, 1, 'h41, 0, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus("hold41",    0, 0, 0, 0, 1, 'h42, 32'h99, 0, 'h42, 0, 0);
    applyStimulus("reset_mid",   1, 1, 'h41, 32'hDEAD, 1, 'h30, 32'hBEEF, 1, 'h41, 1, 'h30);
    applyStimulus("post_rst_wr", 0, 1, 'h50, 32'h12345678, 1, 'h51, 32'h87654321, 1, 'h41, 1, 'h30);
    applyStimulus("post_rst_rd", 0, 0, 0, 0, 0, 0, 0, 1, 'h50, 1, 'h51);

    for (int i = 0; i < 60; i++) begin
      int a1, a2, ra1, ra2;
      a1  = 'h60 + $urandom_range(0, 7);
      a2  = 'h60 + $urandom_range(0, 7);
      ra1 = 'h60 + $urandom_range(0, 7);
      ra2 = 'h60 + $urandom_range(0, 7);
      applyStimulus("random", 0, $urandom_range(0, 1) == 1, a1, $urandom,
                    $urandom_range(0, 1) == 1, a2, $urandom,
                    $urandom_range(0, 1) == 1, ra1, $urandom_range(0, 1) == 1, ra2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lvt_multiport_ram.md
LVT_MULTIPORT_RAM -- requirements
Module: lvt_multiport_ram

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, address width in bits for all ports.
REQ-002 Parameter RAM_DEPTH, default 2**ADDR_WIDTH, number of words; valid addresses are 0..RAM_DEPTH-1.
REQ-003 Parameter DATA_WIDTH, default 32, word width in bits.
REQ-004 aclk  in  1  sole clock; all state updates on its rising edge.
REQ-005 areset  in  1  reset; one clock, synchronous, active-high.
REQ-006 wren1  in  1  write enable, write port 1.
REQ-007 wraddr1  in  ADDR_WIDTH  write address, port 1.
REQ-008 wrdata1  in  DATA_WIDTH  write data, port 1.
REQ-009 wren2 / wraddr2 / wrdata2  in  1 / ADDR_WIDTH / DATA_WIDTH  same meaning for write port 2.
REQ-010 rden1  in  1  read enable, read port 1.
REQ-011 rdaddr1  in  ADDR_WIDTH  read address, port 1.
REQ-012 rddata1  out  DATA_WIDTH  read data, port 1.
REQ-013 rden2 / rdaddr2 / rddata2  in / in / out  same meaning for read port 2.

Function
REQ-014 The block SHALL behave as one shared RAM_DEPTH x DATA_WIDTH memory with 2 independent write ports and 2 independent read ports, all usable every cycle.
REQ-015 Storage SHALL be 2 write banks (one per write port), each replicated once per read port (4 simple-dual-port arrays total); write port k writes only the replicas of bank k.
REQ-016 A live-value table (LVT) SHALL hold, per address, a 1-bit index of the write port that last wrote it.
REQ-017 On a rising edge with wrenk=1, bank k SHALL store wrdatak at wraddrk and LVT[wraddrk] SHALL become k-1 (0 for port 1, 1 for port 2).
REQ-018 When wren1=wren2=1 and wraddr1=wraddr2, port 2 SHALL win: LVT entry becomes 1 and subsequent reads return wrdata2.
REQ-019 Writes to different addresses in the same cycle SHALL both take effect.
REQ-020 With rdenj=1 at edge N, rddataj SHALL present, from edge N+1 until the next update, the word at rdaddrj as of before edge N's writes, chosen from the bank indicated by LVT[rdaddrj] sampled at edge N.
REQ-021 Read latency SHALL be exactly 1 cycle; no handshake, no stalls.
REQ-022 Read-during-write to the same address in the same cycle SHALL return the old value (read-first); the new value is visible to a read issued the following cycle.
REQ-023 With rdenj=0, rddataj SHALL hold its previous value.
REQ-024 Both read ports SHALL be able to read the same or different addresses in the same cycle without interaction.
REQ-025 Addresses SHALL be used as binary indices with no wrap logic; RAM_DEPTH < 2**ADDR_WIDTH leaves out-of-range accesses undefined.
REQ-026 Memory array contents SHALL NOT be initialised or cleared; a read of a never-written address returns an undefined value.

Reset
REQ-027 While areset=1 at a rising edge, every LVT entry SHALL be set to 0 (bank 1) and rddata1, rddata2 SHALL be set to 0.
REQ-028 Writes and reads presented during a reset cycle SHALL be ignored; bank contents are unchanged by reset.
REQ-029 The first cycle after areset deasserts SHALL accept writes and reads normally.
REQ-030 Reset asserted mid-operation SHALL take effect at that edge; a read issued in the same cycle is discarded and its rddata is 0.

Verification
REQ-031 Reset, then wren1 addr 0x10 data 0xAAAA0001; next cycle rden1 and rden2 addr 0x10 -> both rddata = 0xAAAA0001 one cycle later.
REQ-032 Same cycle: wren1 addr 0x05 data 0x11111111, wren2 addr 0x06 data 0x22222222; then read 0x05 on port 1 and 0x06 on port 2 -> 0x11111111 and 0x22222222.
REQ-033 Same cycle: wren1 and wren2 both to addr 0x20, data 0x1 and 0x2; then read 0x20 -> 0x00000002 on both ports.
REQ-034 Write port 2 to 0x30 data 0xB, later write port 1 to 0x30 data 0xC; read 0x30 -> 0x0000000C (LVT tracks last writer).
REQ-035 Address 0x40 holds 0x5; in one cycle write 0x6 to 0x40 and read 0x40 -> 0x5 returned; read again next cycle -> 0x6.
REQ-036 Drive rden1=0 for 3 cycles after a read returning 0x7 -> rddata1 holds 0x7; assert areset one cycle -> rddata1=0, rddata2=0.
